multi_byte_seq: RTL and testbench
=================================

MULTI_BYTE_SEQ -- requirements
Module: multi_byte_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width.
REQ-002 SHALL have parameter OP_OTYPE, default 3'b111, the ALU opcode selecting the FUNC-decoded (O-type) group.
REQ-003 SHALL have port CLK  in  1  rising-edge clock.
REQ-004 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  in  1  request; sampled in IDLE only.
REQ-006 SHALL have port MODE  in  2  operation select: 00 ADD, 01 SHL, 10 SHR, 11 illegal.
REQ-007 SHALL have port LEN  in  2  operand length minus one (1..4 bytes).
REQ-008 SHALL have ports A_BASE, B_BASE, D_BASE  in  ADDR_W  byte-0 (LSB) addresses of source A, source B and destination.
REQ-009 SHALL have port ABORT  in  1  cancel the running operation.
REQ-010 SHALL have ports RD_ADDR_A, RD_ADDR_B  out  ADDR_W  register-file read addresses; the register file reads asynchronously.
REQ-011 SHALL have ports RD_DATA_A, RD_DATA_B  in  8  read data.
REQ-012 SHALL have ports ALU_A, ALU_B  out  8; ALU_OP  out  3; ALU_FUNC  out  3; ALU_OVF_IN  out  1  ALU drive.
REQ-013 SHALL have ports ALU_OUT  in  8; ALU_OVF_OUT  in  1  ALU result and carry/shift-out.
REQ-014 SHALL have ports WR_EN  out  1; WR_ADDR  out  ADDR_W; WR_DATA  out  8  register-file write port, committed on the CLK edge.
REQ-015 SHALL have ports BUSY  out  1; DONE  out  1  one-cycle pulse; ERR  out  1  one-cycle pulse; CARRY  out  1  final carry/shift-out.

Function
REQ-016 SHALL implement states IDLE and RUN; BUSY = (state==RUN).
REQ-017 IDLE, START=1, MODE!=11: SHALL latch MODE, LEN and the three bases, clear the byte counter i and carry register C, and enter RUN.
REQ-018 IDLE, START=1, MODE=11: SHALL stay in IDLE and pulse ERR the next cycle.
REQ-019 START while in RUN SHALL be ignored, with no effect on the running operation.
REQ-020 RUN SHALL process exactly one byte per cycle for LEN+1 cycles; WR_EN=1 in every RUN cycle without ABORT.
REQ-021 Byte index k SHALL be i for ADD and SHL, and LEN-i for SHR.
REQ-022 Addresses SHALL be RD_ADDR_A = A_BASE+k, RD_ADDR_B = B_BASE+k and WR_ADDR = D_BASE+k, all modulo 2^ADDR_W (wrap-around).
REQ-023 ALU_A SHALL equal RD_DATA_A; ALU_B SHALL equal RD_DATA_B for ADD and 0 for shifts; ALU_OVF_IN SHALL equal C; WR_DATA SHALL equal ALU_OUT.
REQ-024 ALU_OP/ALU_FUNC SHALL be opADD for ADD, OP_OTYPE/fnSHIFTL_O for SHL, and OP_OTYPE/fnSHIFTR_O for SHR (definitions package encodings).
REQ-025 Each RUN edge SHALL set C to ALU_OVF_OUT and increment i; on the edge where i==LEN, the block SHALL set CARRY to ALU_OVF_OUT, return to IDLE and pulse DONE the following cycle.
REQ-026 Latency: START accepted at edge t; writes occur at edges t+1..t+LEN+1; DONE is high in the cycle after edge t+LEN+1.
REQ-027 ABORT=1 in RUN SHALL force WR_EN=0 combinationally that cycle, return to IDLE at the edge, suppress DONE and leave CARRY unchanged; ABORT in IDLE SHALL be ignored.
REQ-028 In-place operation (D_BASE==A_BASE) SHALL yield correct results, since each byte is read before it is written.
REQ-029 Outside RUN, the block SHALL drive ALU_A, ALU_B, RD_ADDR_*, WR_ADDR, WR_DATA, ALU_FUNC and ALU_OVF_IN to 0, ALU_OP to opLW, and WR_EN to 0.
REQ-030 CARRY SHALL hold its value until the next completed operation.

Reset
REQ-031 RESET_N=0 SHALL immediately force IDLE, i=0, C=0, CARRY=0, BUSY=0, DONE=0, ERR=0, WR_EN=0, and the REQ-029 idle values, regardless of CLK.
REQ-032 Reset asserted during RUN SHALL abort with no further writes and no DONE pulse; after release the block SHALL accept START at the first rising edge.

Verification
REQ-033 Scenario: ADD, LEN=1, A bytes {FF,01}, B bytes {01,00} -> writes {00,02} at edges t+1, t+2; CARRY=0; DONE at t+3.
REQ-034 Scenario: ADD, LEN=3, A=FFFFFFFF, B=00000001 -> result 00000000, CARRY=1, four WR_EN cycles.
REQ-035 Scenario: SHL, LEN=1, value 0xC001 -> 0x8002, CARRY=1; SHR, LEN=1, value 0x0103 -> 0x0081, CARRY=1, with the MSB address written first.
REQ-036 Scenario: A_BASE=D_BASE=0xF, LEN=1 -> accesses addresses F then 0; result is correct in place.
REQ-037 Scenario: ABORT during the second RUN cycle of LEN=3 -> exactly one write, no DONE, CARRY unchanged; START during RUN is ignored.
REQ-038 Scenario: MODE=11 -> ERR pulse, BUSY stays 0, no writes; RESET_N low mid-RUN -> WR_EN=0 immediately and all outputs take their reset values.

Source files
------------

// File: rtl/multi_byte_seq_if.sv
// Bus bundle for multi_byte_seq: request/control, register-file ports,
// ALU drive/return and status. The master side is the sequencer itself.
interface multi_byte_seq_if #(
  parameter int ADDR_W = 4
);
  logic              START;
  logic [1:0]        MODE;
  logic [1:0]        LEN;
  logic [ADDR_W-1:0] A_BASE;
  logic [ADDR_W-1:0] B_BASE;
  logic [ADDR_W-1:0] D_BASE;
  logic              ABORT;

  logic [ADDR_W-1:0] RD_ADDR_A;
  logic [ADDR_W-1:0] RD_ADDR_B;
  logic [7:0]        RD_DATA_A;
  logic [7:0]        RD_DATA_B;

  logic [7:0]        ALU_A;
  logic [7:0]        ALU_B;
  logic [2:0]        ALU_OP;
  logic [2:0]        ALU_FUNC;
  logic              ALU_OVF_IN;
  logic [7:0]        ALU_OUT;
  logic              ALU_OVF_OUT;

  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;

  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic              CARRY;

  modport master (
    input  START, MODE, LEN, A_BASE, B_BASE, D_BASE, ABORT,
    input  RD_DATA_A, RD_DATA_B, ALU_OUT, ALU_OVF_OUT,
    output RD_ADDR_A, RD_ADDR_B, ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN,
    output WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR, CARRY
  );

  modport slave (
    output START, MODE, LEN, A_BASE, B_BASE, D_BASE, ABORT,
    output RD_DATA_A, RD_DATA_B, ALU_OUT, ALU_OVF_OUT,
    input  RD_ADDR_A, RD_ADDR_B, ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN,
    input  WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR, CARRY
  );
endinterface

// File: rtl/multi_byte_seq.sv
// Multi-byte ADD / shift sequencer. Walks an operand of 1..4 bytes through
// an external 8-bit ALU, one byte per cycle, chaining carry/shift-out
// between bytes and writing each result byte back to the register file.
//
// state | meaning
// IDLE  | waiting for START; all bus drives parked at idle values
// RUN   | processing byte i of LEN+1, one write per cycle
module multi_byte_seq #(
  parameter int         ADDR_W   = 4,
  parameter logic [2:0] OP_OTYPE = 3'b111
) (
  input logic              CLK,
  input logic              RESET_N,
  multi_byte_seq_if.master bus
);

  localparam logic [2:0] OP_LW       = 3'b100;
  localparam logic [2:0] OP_ADD      = 3'b000;
  localparam logic [2:0] FN_NONE     = 3'b000;
  localparam logic [2:0] FN_SHIFTL_O = 3'b001;
  localparam logic [2:0] FN_SHIFTR_O = 3'b010;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SHL = 2'b01;
  localparam logic [1:0] MODE_SHR = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_nx;
  logic [1:0]        mode_q;
  logic [1:0]        len_q;
  logic [1:0]        i_q;
  logic              c_q;
  logic              carry_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] a_q, b_q, d_q;
  logic [1:0]        k;

  // SHR walks from the MSB down so each shift-out feeds the next lower byte
  assign k = (mode_q == MODE_SHR) ? (len_q - i_q) : i_q;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_nx;
  end

  // Next state and all combinational bus drives
  always_comb begin
    state_nx       = state_q;
    bus.RD_ADDR_A  = '0;
    bus.RD_ADDR_B  = '0;
    bus.ALU_A      = 8'h00;
    bus.ALU_B      = 8'h00;
    bus.ALU_OP     = OP_LW;
    bus.ALU_FUNC   = FN_NONE;
    bus.ALU_OVF_IN = 1'b0;
    bus.WR_EN      = 1'b0;
    bus.WR_ADDR    = '0;
    bus.WR_DATA    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (bus.START && bus.MODE != MODE_ILL) state_nx = S_RUN;
      end
      S_RUN: begin
        bus.RD_ADDR_A  = a_q + ADDR_W'(k);
        bus.RD_ADDR_B  = b_q + ADDR_W'(k);
        bus.WR_ADDR    = d_q + ADDR_W'(k);
        bus.ALU_A      = bus.RD_DATA_A;
        bus.ALU_OVF_IN = c_q;
        bus.WR_DATA    = bus.ALU_OUT;
        case (mode_q)
          MODE_SHL: begin
            bus.ALU_OP   = OP_OTYPE;
            bus.ALU_FUNC = FN_SHIFTL_O;
          end
          MODE_SHR: begin
            bus.ALU_OP   = OP_OTYPE;
            bus.ALU_FUNC = FN_SHIFTR_O;
          end
          default: begin
            bus.ALU_OP = OP_ADD;
            bus.ALU_B  = bus.RD_DATA_B;
          end
        endcase
        if (bus.ABORT) begin
          state_nx = S_IDLE;
        end else begin
          bus.WR_EN = 1'b1;
          if (i_q == len_q) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operation context, byte counter, carry chain and status pulses
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q  <= MODE_ADD;
      len_q   <= 2'd0;
      i_q     <= 2'd0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        if (bus.START && bus.MODE == MODE_ILL) begin
          err_q <= 1'b1;
        end else if (bus.START) begin
          mode_q <= bus.MODE;
          len_q  <= bus.LEN;
          a_q    <= bus.A_BASE;
          b_q    <= bus.B_BASE;
          d_q    <= bus.D_BASE;
          i_q    <= 2'd0;
          c_q    <= 1'b0;
        end
      end else if (!bus.ABORT) begin
        c_q <= bus.ALU_OVF_OUT;
        i_q <= i_q + 2'd1;
        if (i_q == len_q) begin
          carry_q <= bus.ALU_OVF_OUT;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.BUSY  = (state_q == S_RUN);
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
  assign bus.CARRY = carry_q;

endmodule

// File: tb/tb_multi_byte_seq.sv
// Directed bench for multi_byte_seq with a behavioural register file and ALU.
module tb_multi_byte_seq;
  localparam int         ADDR_W      = 4;
  localparam logic [2:0] OP_OTYPE    = 3'b111;
  localparam logic [2:0] OP_LW       = 3'b100;
  localparam logic [2:0] OP_ADD      = 3'b000;
  localparam logic [2:0] FN_SHIFTL_O = 3'b001;
  localparam logic [2:0] FN_SHIFTR_O = 3'b010;

  logic CLK = 1'b0;
  logic RESET_N;

  multi_byte_seq_if #(.ADDR_W(ADDR_W)) bus ();

  multi_byte_seq #(.ADDR_W(ADDR_W), .OP_OTYPE(OP_OTYPE)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus.master)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [16];
  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;
  logic [3:0] wr_log [64];
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         checks   = 0;
  int         errors   = 0;

  // Register file (async read, write on edge) plus event counters
  always @(posedge CLK) begin
    if (bus.WR_EN) begin
      mem[bus.WR_ADDR]   <= bus.WR_DATA;
      wr_log[wr_cnt[5:0]] <= bus.WR_ADDR;
      wr_cnt             <= wr_cnt + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
    if (bus.DONE) done_cnt <= done_cnt + 1;
    if (bus.ERR)  err_cnt  <= err_cnt + 1;
  end

  assign bus.RD_DATA_A = mem[bus.RD_ADDR_A];
  assign bus.RD_DATA_B = mem[bus.RD_ADDR_B];

  // Behavioural ALU
  logic [8:0] sum;
  always_comb begin
    sum             = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B} + {8'h00, bus.ALU_OVF_IN};
    bus.ALU_OUT     = 8'h00;
    bus.ALU_OVF_OUT = 1'b0;
    if (bus.ALU_OP == OP_ADD) begin
      bus.ALU_OUT     = sum[7:0];
      bus.ALU_OVF_OUT = sum[8];
    end else if (bus.ALU_OP == OP_OTYPE && bus.ALU_FUNC == FN_SHIFTL_O) begin
      bus.ALU_OUT     = {bus.ALU_A[6:0], bus.ALU_OVF_IN};
      bus.ALU_OVF_OUT = bus.ALU_A[7];
    end else if (bus.ALU_OP == OP_OTYPE && bus.ALU_FUNC == FN_SHIFTR_O) begin
      bus.ALU_OUT     = {bus.ALU_OVF_IN, bus.ALU_A[7:1]};
      bus.ALU_OVF_OUT = bus.ALU_A[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge CLK);
    #1 pre_we = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [1:0] l,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    @(negedge CLK);
    bus.MODE = m; bus.LEN = l; bus.A_BASE = a; bus.B_BASE = b; bus.D_BASE = d;
    bus.START = 1'b1;
    @(posedge CLK);
    #1 bus.START = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (bus.DONE) begin
        n = c;
        break;
      end
    end
  endtask

  int n, w0, d0, e0;

  initial begin
    RESET_N = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.START = 1'b0; bus.MODE = 2'b00; bus.LEN = 2'd0; bus.ABORT = 1'b0;
    bus.A_BASE = '0; bus.B_BASE = '0; bus.D_BASE = '0;
    #2;
    chk("rst_busy",  bus.BUSY,   0);
    chk("rst_wr_en", bus.WR_EN,  0);
    chk("rst_alu_op", bus.ALU_OP, OP_LW);
    chk("rst_carry", bus.CARRY,  0);
    chk("rst_done",  bus.DONE,   0);
    chk("rst_err",   bus.ERR,    0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // ADD LEN=1: {01FF} + {0001} = {0200}
    poke(4'h0, 8'hFF); poke(4'h1, 8'h01); poke(4'h4, 8'h01); poke(4'h5, 8'h00);
    w0 = wr_cnt;
    start_op(2'b00, 2'd1, 4'h0, 4'h4, 4'h8);
    @(negedge CLK);
    chk("s1_c1_wr_en", bus.WR_EN, 1);
    chk("s1_c1_addr",  bus.WR_ADDR, 4'h8);
    chk("s1_c1_data",  bus.WR_DATA, 8'h00);
    @(negedge CLK);
    chk("s1_c2_addr",  bus.WR_ADDR, 4'h9);
    chk("s1_c2_data",  bus.WR_DATA, 8'h02);
    chk("s1_c2_ovfin", bus.ALU_OVF_IN, 1);
    @(negedge CLK);
    chk("s1_done",  bus.DONE, 1);
    chk("s1_idle_busy", bus.BUSY, 0);
    chk("s1_carry", bus.CARRY, 0);
    chk("s1_writes", wr_cnt - w0, 2);
    chk("s1_result", {mem[9], mem[8]}, 16'h0200);
    @(negedge CLK);
    chk("s1_done_pulse", bus.DONE, 0);

    // ADD LEN=3: FFFFFFFF + 00000001
    for (int j = 0; j < 4; j++) poke(4'(j), 8'hFF);
    poke(4'h4, 8'h01); poke(4'h5, 8'h00); poke(4'h6, 8'h00); poke(4'h7, 8'h00);
    w0 = wr_cnt;
    start_op(2'b00, 2'd3, 4'h0, 4'h4, 4'h8);
    wait_done(n);
    chk("s2_latency", n, 5);
    chk("s2_writes", wr_cnt - w0, 4);
    chk("s2_result", {mem[11], mem[10], mem[9], mem[8]}, 32'h0000_0000);
    chk("s2_carry", bus.CARRY, 1);

    // SHL 0xC001 -> 0x8002
    poke(4'h0, 8'h01); poke(4'h1, 8'hC0);
    start_op(2'b01, 2'd1, 4'h0, 4'h4, 4'h8);
    wait_done(n);
    chk("shl_latency", n, 3);
    chk("shl_result", {mem[9], mem[8]}, 16'h8002);
    chk("shl_carry", bus.CARRY, 1);

    // SHR 0x0103 -> 0x0081, MSB first
    poke(4'h0, 8'h03); poke(4'h1, 8'h01);
    w0 = wr_cnt;
    start_op(2'b10, 2'd1, 4'h0, 4'h4, 4'h8);
    wait_done(n);
    chk("shr_first_addr", wr_log[w0[5:0]], 4'h9);
    chk("shr_second_addr", wr_log[6'(w0 + 1)], 4'h8);
    chk("shr_result", {mem[9], mem[8]}, 16'h0081);
    chk("shr_carry", bus.CARRY, 1);

    // In place with wrap: A=D=F, {01,80} + {02,80} = {04,00}
    poke(4'hF, 8'h80); poke(4'h0, 8'h01); poke(4'h4, 8'h80); poke(4'h5, 8'h02);
    w0 = wr_cnt;
    start_op(2'b00, 2'd1, 4'hF, 4'h4, 4'hF);
    wait_done(n);
    chk("wrap_latency", n, 3);
    chk("wrap_first_addr", wr_log[w0[5:0]], 4'hF);
    chk("wrap_second_addr", wr_log[6'(w0 + 1)], 4'h0);
    chk("wrap_result", {mem[0], mem[15]}, 16'h0400);
    chk("wrap_carry", bus.CARRY, 0);

    // ABORT in second RUN cycle; START during RUN ignored
    for (int j = 0; j < 4; j++) poke(4'(j), 8'hFF);
    poke(4'h4, 8'h01); poke(4'h5, 8'h00); poke(4'h6, 8'h00); poke(4'h7, 8'h00);
    poke(4'h8, 8'h5A); poke(4'h9, 8'h5A);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    start_op(2'b00, 2'd3, 4'h0, 4'h4, 4'h8);
    @(negedge CLK);
    chk("ab_c1_wr_en", bus.WR_EN, 1);
    bus.START = 1'b1; bus.MODE = 2'b11; bus.LEN = 2'd0; bus.A_BASE = 4'h7; bus.D_BASE = 4'h2;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("ab_ignore_addr", bus.WR_ADDR, 4'h9);
    chk("ab_ignore_op", bus.ALU_OP, OP_ADD);
    bus.ABORT = 1'b1;
    #1;
    chk("ab_wr_en_low", bus.WR_EN, 0);
    chk("ab_busy", bus.BUSY, 1);
    @(posedge CLK);
    #1 bus.ABORT = 1'b0;
    @(negedge CLK);
    chk("ab_back_idle", bus.BUSY, 0);
    repeat (3) @(negedge CLK);
    chk("ab_writes", wr_cnt - w0, 1);
    chk("ab_no_done", done_cnt - d0, 0);
    chk("ab_no_err", err_cnt - e0, 0);
    chk("ab_bytes", {mem[9], mem[8]}, 16'h5A00);
    chk("ab_carry", bus.CARRY, 0);

    // ABORT in IDLE ignored: START accepted alongside it
    poke(4'h0, 8'hFF); poke(4'h4, 8'h01);
    @(negedge CLK);
    bus.MODE = 2'b00; bus.LEN = 2'd0; bus.A_BASE = 4'h0; bus.B_BASE = 4'h4; bus.D_BASE = 4'h8;
    bus.START = 1'b1; bus.ABORT = 1'b1;
    @(posedge CLK);
    #1 begin bus.START = 1'b0; bus.ABORT = 1'b0; end
    wait_done(n);
    chk("idle_abort_latency", n, 2);
    chk("idle_abort_result", mem[8], 8'h00);
    chk("idle_abort_carry", bus.CARRY, 1);

    // Illegal mode
    w0 = wr_cnt;
    start_op(2'b11, 2'd1, 4'h0, 4'h4, 4'h8);
    @(negedge CLK);
    chk("ill_err", bus.ERR, 1);
    chk("ill_busy", bus.BUSY, 0);
    @(negedge CLK);
    chk("ill_err_pulse", bus.ERR, 0);
    chk("ill_writes", wr_cnt - w0, 0);

    // Reset mid-RUN, then restart on first edge after release
    start_op(2'b00, 2'd3, 4'h0, 4'h4, 4'h8);
    @(negedge CLK);
    @(negedge CLK);
    chk("rr_wr_en_before", bus.WR_EN, 1);
    w0 = wr_cnt; d0 = done_cnt;
    RESET_N = 1'b0;
    #1;
    chk("rr_wr_en", bus.WR_EN, 0);
    chk("rr_busy", bus.BUSY, 0);
    chk("rr_alu_op", bus.ALU_OP, OP_LW);
    chk("rr_wr_addr", bus.WR_ADDR, 0);
    chk("rr_carry", bus.CARRY, 0);
    repeat (3) @(negedge CLK);
    chk("rr_no_writes", wr_cnt - w0, 0);
    chk("rr_no_done", done_cnt - d0, 0);
    RESET_N = 1'b1;
    bus.MODE = 2'b00; bus.LEN = 2'd0; bus.START = 1'b1;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    @(negedge CLK);
    chk("rr_restart_busy", bus.BUSY, 1);
    @(negedge CLK);
    chk("rr_restart_done", bus.DONE, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
